// File: rtl/usb_out_rx_crc.sv
`timescale 1ns/1ps
// usb_out_rx_crc: USB OUT data-phase receive stage in front of the OUT FIFO.
// Holds back the two trailing CRC16 bytes, checks the CRC, enforces the maximum
// packet size and drives the FIFO commit/abort strobes plus the handshake.
// Optional feature: define USB_OUT_RX_TOGGLE_EN to enable DATA0/DATA1 toggle
// checking (retransmissions are ACKed but aborted in the FIFO).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rx_start_i, rx_data1_i       data phase start pulse, PID was DATA1
//   rx_data_i, rx_valid_i        received byte and its strobe
//   rx_eop_i, rx_err_i           end of packet, receive error pulses
//   out_data_o, out_valid_o,
//   out_err_o, out_ready_o       FIFO push / commit / abort strobe group
//   out_nak_i                    FIFO NAK latch
//   hs_o, hs_valid_o             handshake code (00/01 ACK/10 NAK/11 silent)
module usb_out_rx_crc #(
  parameter int unsigned OUT_MAXPACKETSIZE = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_start_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_eop_i,
  input  logic       rx_err_i,
  input  logic       rx_data1_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  output logic       out_err_o,
  output logic       out_ready_o,
  input  logic       out_nak_i,
  output logic [1:0] hs_o,
  output logic       hs_valid_o
);

  localparam int unsigned CNT_W          = $clog2(OUT_MAXPACKETSIZE + 1);
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE   = 16'hB001;
  localparam logic [15:0] CRC_POLY_REFL = 16'hA001;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_END, ST_DROP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       old_q, old_d;
  logic [7:0]       new_q, new_d;
  logic [1:0]       held_q, held_d;
  logic [CNT_W-1:0] pcount_q, pcount_d;
  logic [7:0]       out_data_d;
  logic             out_valid_d, out_err_d, out_ready_d;
  logic [1:0]       hs_d;
  logic             hs_valid_d;

`ifdef USB_OUT_RX_TOGGLE_EN
  logic data1_q, data1_d;
  logic exp_q, exp_d;
`else
  logic unused_data1;
  assign unused_data1 = rx_data1_i;
`endif

  // Reflected CRC16 (0x8005) update over one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      old_q       <= 8'h00;
      new_q       <= 8'h00;
      held_q      <= 2'd0;
      pcount_q    <= '0;
      out_data_o  <= 8'h00;
      out_valid_o <= 1'b0;
      out_err_o   <= 1'b0;
      out_ready_o <= 1'b0;
      hs_o        <= 2'b00;
      hs_valid_o  <= 1'b0;
`ifdef USB_OUT_RX_TOGGLE_EN
      data1_q     <= 1'b0;
      exp_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      old_q       <= old_d;
      new_q       <= new_d;
      held_q      <= held_d;
      pcount_q    <= pcount_d;
      out_data_o  <= out_data_d;
      out_valid_o <= out_valid_d;
      out_err_o   <= out_err_d;
      out_ready_o <= out_ready_d;
      hs_o        <= hs_d;
      hs_valid_o  <= hs_valid_d;
`ifdef USB_OUT_RX_TOGGLE_EN
      data1_q     <= data1_d;
      exp_q       <= exp_d;
`endif
    end
  end

  // Next-state, datapath and strobe generation.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    old_d       = old_q;
    new_d       = new_q;
    held_d      = held_q;
    pcount_d    = pcount_q;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;
    out_err_d   = 1'b0;
    out_ready_d = 1'b0;
    hs_d        = 2'b00;
    hs_valid_d  = 1'b0;
`ifdef USB_OUT_RX_TOGGLE_EN
    data1_d     = data1_q;
    exp_d       = exp_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rx_start_i) begin
          state_d  = ST_DATA;
          crc_d    = CRC_INIT;
          old_d    = 8'h00;
          new_d    = 8'h00;
          held_d   = 2'd0;
          pcount_d = '0;
`ifdef USB_OUT_RX_TOGGLE_EN
          data1_d  = rx_data1_i;
`endif
        end
      end

      ST_DATA: begin
        if (rx_err_i) begin
          // Error beats every simultaneous event; a coincident EOP closes the packet.
          out_ready_d = 1'b1;
          out_err_d   = 1'b1;
          hs_d        = 2'b11;
          hs_valid_d  = 1'b1;
          state_d     = rx_eop_i ? ST_IDLE : ST_DROP;
        end else if (rx_start_i) begin
          // Missing EOP: abort the old packet and restart on this new one.
          out_ready_d = 1'b1;
          out_err_d   = 1'b1;
          hs_d        = 2'b11;
          hs_valid_d  = 1'b1;
          crc_d       = CRC_INIT;
          old_d       = 8'h00;
          new_d       = 8'h00;
          held_d      = 2'd0;
          pcount_d    = '0;
`ifdef USB_OUT_RX_TOGGLE_EN
          data1_d     = rx_data1_i;
`endif
        end else begin
          if (rx_valid_i) begin
            crc_d = crc16_byte(crc_q, rx_data_i);
            old_d = new_q;
            new_d = rx_data_i;
            if (held_q == 2'd2) begin
              if (pcount_q == CNT_W'(OUT_MAXPACKETSIZE)) begin
                out_ready_d = 1'b1;
                out_err_d   = 1'b1;
                hs_d        = 2'b11;
                hs_valid_d  = 1'b1;
                state_d     = rx_eop_i ? ST_IDLE : ST_DROP;
              end else begin
                out_ready_d = 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = old_q;
                pcount_d    = pcount_q + CNT_W'(1);
              end
            end else begin
              held_d = held_q + 2'd1;
            end
          end
          if (rx_eop_i && state_d == ST_DATA) state_d = ST_END;
        end
      end

      ST_END: begin
        out_ready_d = 1'b1;
        hs_valid_d  = 1'b1;
        state_d     = ST_IDLE;
        if (held_q != 2'd2 || crc_q != CRC_RESIDUE) begin
          out_err_d = 1'b1;
          hs_d      = 2'b11;
        end else begin
          hs_d = out_nak_i ? 2'b10 : 2'b01;
`ifdef USB_OUT_RX_TOGGLE_EN
          // ACKed retransmission: drop the duplicate data but keep the toggle.
          if (!out_nak_i) begin
            if (data1_q == exp_q) exp_d     = ~exp_q;
            else                  out_err_d = 1'b1;
          end
`endif
        end
      end

      ST_DROP: begin
        if (rx_eop_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_out_rx_crc.sv
`timescale 1ns/1ps
// tb_usb_out_rx_crc: table-driven plus randomized bench for usb_out_rx_crc.
module tb_usb_out_rx_crc;

  localparam int MAXP = 8;
  localparam int GAP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_eop = 1'b0;
  logic       rx_err = 1'b0;
  logic       rx_data1 = 1'b0;
  logic       out_nak = 1'b0;
  logic [7:0] out_data_o;
  logic       out_valid_o, out_err_o, out_ready_o;
  logic [1:0] hs_o;
  logic       hs_valid_o;

  usb_out_rx_crc #(.OUT_MAXPACKETSIZE(MAXP)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_start_i(rx_start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_eop_i(rx_eop), .rx_err_i(rx_err), .rx_data1_i(rx_data1),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_err_o(out_err_o),
    .out_ready_o(out_ready_o), .out_nak_i(out_nak),
    .hs_o(hs_o), .hs_valid_o(hs_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    int         plen;
    bit         corrupt;
    bit         nak;
    int         err_at;
    bit         eop_last;
    int         exp_pushes;
    int         exp_term;   // 0 commit, 1 abort
    logic [1:0] exp_hs;
    bit         lat;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  ev_t        evq[$];
  logic [1:0] hsq[$];
  int         vcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every FIFO strobe and handshake away from the active edge.
  always @(negedge clk) begin
    if (out_ready_o) evq.push_back('{out_valid_o, out_err_o, out_data_o, cyc});
    if (hs_valid_o)  hsq.push_back(hs_o);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // USB CRC16 computed in the non-reflected MSB-first form, then bit-reversed.
  function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
    logic [15:0] r;
    logic [15:0] rev;
    logic        fb;
    r = 16'hFFFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = r[15] ^ b[i][j];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    for (int j = 0; j < 16; j++) rev[j] = r[15-j];
    return rev;
  endfunction

  task automatic model(input int plen, input bit corrupt, input bit nak, input int err_at,
                       output int pushes, output int term, output logic [1:0] hs);
    int a;
    a = (err_at >= 0) ? ((err_at > 2) ? err_at - 2 : 0) : plen;
    if (a > MAXP) begin
      pushes = MAXP; term = 1; hs = 2'b11;
    end else if (err_at >= 0 || corrupt) begin
      pushes = a; term = 1; hs = 2'b11;
    end else begin
      pushes = plen; term = 0; hs = nak ? 2'b10 : 2'b01;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    evq.delete();
    hsq.delete();
    vcyc.delete();
  endtask

  task automatic start_pkt(input logic d1);
    rx_start = 1'b1;
    rx_data1 = d1;
    tick();
    rx_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic err, input logic eop);
    repeat (GAP - 1) tick();
    rx_data  = d;
    rx_valid = 1'b1;
    rx_err   = err;
    rx_eop   = eop;
    tick();
    vcyc.push_back(cyc);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rx_eop   = 1'b0;
  endtask

  task automatic pulse_eop();
    repeat (GAP - 1) tick();
    rx_eop = 1'b1;
    tick();
    rx_eop = 1'b0;
  endtask

  task automatic run_pkt(input logic [7:0] payload[$], input bit corrupt, input bit nak,
                         input int err_at, input bit eop_last, input logic d1);
    logic [7:0]  bytes[$];
    logic [15:0] rc;
    bytes = payload;
    rc = model_crc(payload);
    bytes.push_back(~rc[7:0]);
    bytes.push_back(~rc[15:8] ^ {7'b0, corrupt});
    clear_obs();
    out_nak = nak;
    start_pkt(d1);
    foreach (bytes[i])
      send_byte(bytes[i], i == err_at, eop_last && (i == bytes.size() - 1));
    if (!eop_last) pulse_eop();
    repeat (8) tick();
    out_nak = 1'b0;
  endtask

  task automatic analyze(input string name, input logic [7:0] payload[$], input int exp_pushes,
                         input int exp_term, input logic [1:0] exp_hs, input bit lat);
    int   np;
    int   nt;
    logic terr;
    np = 0; nt = 0; terr = 1'b0;
    foreach (evq[i]) begin
      if (evq[i].valid) begin
        if (np < payload.size()) check({name, ".data"}, evq[i].data, payload[np]);
        check({name, ".push_err"}, evq[i].err, 0);
        if (lat && (np + 2) < vcyc.size()) check({name, ".latency"}, evq[i].cyc, vcyc[np + 2]);
        np++;
      end else begin
        nt++;
        terr = evq[i].err;
      end
    end
    check({name, ".pushes"}, np, exp_pushes);
    check({name, ".terminators"}, nt, 1);
    if (nt > 0) begin
      check({name, ".term_err"}, terr, exp_term);
      check({name, ".term_last"}, evq[$].valid, 0);
    end
    check({name, ".hs_count"}, hsq.size(), 1);
    if (hsq.size() > 0) check({name, ".hs"}, hsq[0], exp_hs);
  endtask

  initial begin
    vec_t       vecs[9];
    logic [7:0] pl[$];
    int         ep, et;
    logic [1:0] eh;

    vecs[0] = '{0, 1'b0, 1'b0, -1, 1'b1, 0, 0, 2'b01, 1'b0};  // zero-length
    vecs[1] = '{3, 1'b0, 1'b0, -1, 1'b1, 3, 0, 2'b01, 1'b1};  // 11 22 33 good
    vecs[2] = '{3, 1'b1, 1'b0, -1, 1'b1, 3, 1, 2'b11, 1'b0};  // bad CRC
    vecs[3] = '{9, 1'b0, 1'b0, -1, 1'b0, 8, 1, 2'b11, 1'b0};  // overflow, late eop
    vecs[4] = '{2, 1'b0, 1'b1, -1, 1'b1, 2, 0, 2'b10, 1'b0};  // NAK
    vecs[5] = '{3, 1'b0, 1'b0,  3, 1'b0, 1, 1, 2'b11, 1'b0};  // err on 4th byte
    vecs[6] = '{8, 1'b0, 1'b0, -1, 1'b0, 8, 0, 2'b01, 1'b1};  // exactly max
    vecs[7] = '{9, 1'b0, 1'b0, -1, 1'b1, 8, 1, 2'b11, 1'b0};  // overflow on eop byte
    vecs[8] = '{4, 1'b0, 1'b0,  5, 1'b1, 3, 1, 2'b11, 1'b0};  // err with valid+eop

    // Reset state.
    repeat (3) tick();
    check("reset.out_ready", out_ready_o, 0);
    check("reset.out_valid", out_valid_o, 0);
    check("reset.out_err", out_err_o, 0);
    check("reset.out_data", out_data_o, 0);
    check("reset.hs", hs_o, 0);
    check("reset.hs_valid", hs_valid_o, 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int v = 0; v < 9; v++) begin
      pl.delete();
      for (int i = 0; i < vecs[v].plen; i++) pl.push_back(8'((i + 1) * 17));
      run_pkt(pl, vecs[v].corrupt, vecs[v].nak, vecs[v].err_at, vecs[v].eop_last, 1'b0);
      analyze($sformatf("vec%0d", v), pl, vecs[v].exp_pushes, vecs[v].exp_term,
              vecs[v].exp_hs, vecs[v].lat);
    end

    // Single byte then EOP: too short for a CRC.
    clear_obs();
    start_pkt(1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    repeat (8) tick();
    pl.delete();
    analyze("short", pl, 0, 1, 2'b11, 1'b0);

    // Start while in DATA: abort the old packet, then receive the new one.
    clear_obs();
    start_pkt(1'b0);
    send_byte(8'hA1, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0);
    send_byte(8'hA3, 1'b0, 1'b0);
    repeat (GAP - 1) tick();
    start_pkt(1'b0);
    pl.delete();
    pl.push_back(8'h5A);
    begin
      logic [15:0] rc;
      rc = model_crc(pl);
      send_byte(8'h5A, 1'b0, 1'b0);
      send_byte(~rc[7:0], 1'b0, 1'b0);
      send_byte(~rc[15:8], 1'b0, 1'b1);
    end
    repeat (8) tick();
    check("restart.events", evq.size(), 4);
    if (evq.size() == 4) begin
      check("restart.push0", {evq[0].valid, evq[0].err, evq[0].data}, {2'b10, 8'hA1});
      check("restart.abort", {evq[1].valid, evq[1].err}, 2'b01);
      check("restart.push1", {evq[2].valid, evq[2].err, evq[2].data}, {2'b10, 8'h5A});
      check("restart.commit", {evq[3].valid, evq[3].err}, 2'b00);
    end
    check("restart.hs_count", hsq.size(), 2);
    if (hsq.size() == 2) begin
      check("restart.hs0", hsq[0], 2'b11);
      check("restart.hs1", hsq[1], 2'b01);
    end

    // Reset mid-packet: no strobe, clean restart afterwards.
    clear_obs();
    start_pkt(1'b0);
    send_byte(8'hC1, 1'b0, 1'b0);
    send_byte(8'hC2, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    pulse_eop();
    repeat (8) tick();
    check("rstmid.events", evq.size(), 1);
    check("rstmid.hs_count", hsq.size(), 0);
    pl.delete();
    run_pkt(pl, 1'b0, 1'b0, -1, 1'b1, 1'b0);
    analyze("rstmid.zlp", pl, 0, 0, 2'b01, 1'b0);

    // Randomized packets against the reference model.
    for (int n = 0; n < 40; n++) begin
      int plen, err_at;
      bit corrupt, nak, eop_last;
      plen     = $urandom_range(0, 11);
      corrupt  = ($urandom_range(0, 3) == 0);
      nak      = $urandom_range(0, 1) == 1;
      eop_last = $urandom_range(0, 1) == 1;
      err_at   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, plen + 1) : -1;
      pl.delete();
      for (int i = 0; i < plen; i++) pl.push_back(8'($urandom));
      model(plen, corrupt, nak, err_at, ep, et, eh);
      run_pkt(pl, corrupt, nak, err_at, eop_last, 1'($urandom));
      analyze($sformatf("rand%0d", n), pl, ep, et, eh, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
